// File: rtl/game_pkg.sv
// Types, fail-cause codes and default widths shared by the round sequencer
// and the game controller.
package game_pkg;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DIGIT_W = 4;

    localparam logic FAIL_WRONG   = 1'b0;
    localparam logic FAIL_TIMEOUT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        P_FETCH,
        P_SHOW,
        P_GAP,
        I_FETCH,
        I_WAIT,
        PASS,
        FAIL
    } seq_state_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Round sequencer bus: controller handshake, sequence RAM port, display and keypad.
interface round_sequencer_if #(
    parameter int unsigned ADDR_W  = game_pkg::ADDR_W,
    parameter int unsigned DIGIT_W = game_pkg::DIGIT_W
);
    logic               Start;
    logic [ADDR_W-1:0]  Level;
    logic [ADDR_W-1:0]  SeqAddr;
    logic [DIGIT_W-1:0] RAMOutput;
    logic               PlayerLoad;
    logic [DIGIT_W-1:0] PlayerNum;
    logic [DIGIT_W-1:0] DispDigit;
    logic               DispEn;
    logic               Busy;
    logic               InputPhase;
    logic               Pass;
    logic               Fail;
    logic               FailCause;

    modport master (
        output Start, Level, RAMOutput, PlayerLoad, PlayerNum,
        input  SeqAddr, DispDigit, DispEn, Busy, InputPhase, Pass, Fail, FailCause
    );

    modport slave (
        input  Start, Level, RAMOutput, PlayerLoad, PlayerNum,
        output SeqAddr, DispDigit, DispEn, Busy, InputPhase, Pass, Fail, FailCause
    );
endinterface

// File: rtl/tick_counter.sv
// Loadable down-counter of timebase ticks; done_c_o flags the tick that
// completes the loaded interval.
module tick_counter #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             clear_i,
    output logic             done_c_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign done_c_o = tick_i && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// One memory-game round: play the stored digits to the display, then collect
// and check the player's entries against the same RAM contents.
module round_sequencer #(
    parameter int unsigned ADDR_W    = game_pkg::ADDR_W,
    parameter int unsigned DIGIT_W   = game_pkg::DIGIT_W,
    parameter int unsigned ON_TICKS  = 4,
    parameter int unsigned OFF_TICKS = 2,
    parameter int unsigned TO_TICKS  = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Tick,
    round_sequencer_if.slave    bus
);
    import game_pkg::*;

    localparam int unsigned CNT_W = $clog2(max3(ON_TICKS, OFF_TICKS, TO_TICKS) + 1);

    seq_state_t         state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0]  lvl_q, lvl_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DIGIT_W-1:0] exp_q, exp_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               fph_q, fph_d;
    logic               disp_en_q, disp_en_d;
    logic               busy_q, busy_d;
    logic               in_phase_q, in_phase_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               cause_q, cause_d;

    logic               cnt_load_c, cnt_clear_c, done_c;
    logic [CNT_W-1:0]   cnt_val_c;

    // One counter serves the ON, OFF and timeout intervals in turn.
    tick_counter #(.CNT_W(CNT_W)) u_tick_counter (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .tick_i     (Tick),
        .load_i     (cnt_load_c),
        .load_val_i (cnt_val_c),
        .clear_i    (cnt_clear_c),
        .done_c_o   (done_c)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lvl_d       = lvl_q;
        addr_d      = addr_q;
        exp_d       = exp_q;
        digit_d     = digit_q;
        fph_d       = fph_q;
        disp_en_d   = disp_en_q;
        busy_d      = busy_q;
        in_phase_d  = in_phase_q;
        pass_d      = 1'b0;
        fail_d      = 1'b0;
        cause_d     = cause_q;
        cnt_load_c  = 1'b0;
        cnt_clear_c = 1'b0;
        cnt_val_c   = CNT_W'(ON_TICKS);

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    lvl_d   = bus.Level;
                    idx_d   = '0;
                    addr_d  = '0;
                    fph_d   = 1'b0;
                    busy_d  = 1'b1;
                    cause_d = FAIL_WRONG;
                    state_d = P_FETCH;
                end
            end
            // Fetch: the address is already out; data is captured on the 2nd cycle.
            P_FETCH, I_FETCH: begin
                fph_d = ~fph_q;
                if (fph_q) begin
                    exp_d      = bus.RAMOutput;
                    cnt_load_c = 1'b1;
                    if (state_q == P_FETCH) begin
                        digit_d   = bus.RAMOutput;
                        disp_en_d = 1'b1;
                        cnt_val_c = CNT_W'(ON_TICKS);
                        state_d   = P_SHOW;
                    end else begin
                        cnt_val_c = CNT_W'(TO_TICKS);
                        state_d   = I_WAIT;
                    end
                end
            end
            P_SHOW: begin
                if (done_c) begin
                    disp_en_d  = 1'b0;
                    cnt_load_c = 1'b1;
                    cnt_val_c  = CNT_W'(OFF_TICKS);
                    state_d    = P_GAP;
                end
            end
            P_GAP: begin
                if (done_c) begin
                    if (idx_q < lvl_q) begin
                        idx_d   = ADDR_W'(idx_q + 1'b1);
                        addr_d  = ADDR_W'(idx_q + 1'b1);
                        state_d = P_FETCH;
                    end else begin
                        idx_d       = '0;
                        addr_d      = '0;
                        in_phase_d  = 1'b1;
                        cnt_clear_c = 1'b1;
                        state_d     = I_FETCH;
                    end
                end
            end
            // A key press outranks a timeout completing in the same cycle.
            I_WAIT: begin
                if (bus.PlayerLoad) begin
                    if (bus.PlayerNum == exp_q) begin
                        if (idx_q == lvl_q) begin
                            pass_d  = 1'b1;
                            state_d = PASS;
                        end else begin
                            idx_d       = ADDR_W'(idx_q + 1'b1);
                            addr_d      = ADDR_W'(idx_q + 1'b1);
                            cnt_clear_c = 1'b1;
                            state_d     = I_FETCH;
                        end
                    end else begin
                        cause_d = FAIL_WRONG;
                        fail_d  = 1'b1;
                        state_d = FAIL;
                    end
                end else if (done_c) begin
                    cause_d = FAIL_TIMEOUT;
                    fail_d  = 1'b1;
                    state_d = FAIL;
                end
            end
            PASS, FAIL: begin
                busy_d     = 1'b0;
                in_phase_d = 1'b0;
                idx_d      = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            lvl_q      <= '0;
            addr_q     <= '0;
            exp_q      <= '0;
            digit_q    <= '0;
            fph_q      <= 1'b0;
            disp_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            in_phase_q <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            cause_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            lvl_q      <= lvl_d;
            addr_q     <= addr_d;
            exp_q      <= exp_d;
            digit_q    <= digit_d;
            fph_q      <= fph_d;
            disp_en_q  <= disp_en_d;
            busy_q     <= busy_d;
            in_phase_q <= in_phase_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            cause_q    <= cause_d;
        end
    end

    assign bus.SeqAddr    = addr_q;
    assign bus.DispDigit  = digit_q;
    assign bus.DispEn     = disp_en_q;
    assign bus.Busy       = busy_q;
    assign bus.InputPhase = in_phase_q;
    assign bus.Pass       = pass_q;
    assign bus.Fail       = fail_q;
    assign bus.FailCause  = cause_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: stimulus queues expected displays and
// round results, a negedge monitor pops and compares them as the DUT emits.
module tb_round_sequencer;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DIGIT_W = 4;

    logic clk, rst, tick;
    int   tphase;
    int   n_vec, n_err;

    logic [DIGIT_W-1:0] mem [32];
    logic [DIGIT_W-1:0] ram_rd;
    int exp_dig [3];

    int disp_q [$];   // (digit << 8) | address
    int res_q  [$];   // 0 pass, 1 wrong digit, 2 timeout

    round_sequencer_if #(.ADDR_W(ADDR_W), .DIGIT_W(DIGIT_W)) bus ();

    round_sequencer #(
        .ADDR_W(ADDR_W), .DIGIT_W(DIGIT_W),
        .ON_TICKS(4), .OFF_TICKS(2), .TO_TICKS(16)
    ) dut (
        .Clk  (clk),
        .Rst  (rst),
        .Tick (tick),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Tick every 4th cycle, changing 1 time unit after the rising edge.
    initial begin
        tick   = 1'b0;
        tphase = 0;
        forever begin
            @(posedge clk);
            #1;
            tphase = (tphase + 1) % 4;
            tick   = (tphase == 0);
        end
    end

    // Sequence RAM model with one-cycle read latency.
    always @(posedge clk) ram_rd <= mem[bus.SeqAddr];
    assign bus.RAMOutput = ram_rd;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Inputs change 2 time units after the rising edge, after Tick has settled.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_round(input int lvl, input int res);
        for (int i = 0; i <= lvl; i++) disp_q.push_back((exp_dig[i] << 8) | i);
        res_q.push_back(res);
    endtask

    task automatic start_round(input int lvl);
        bus.Level = ADDR_W'(lvl);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
    endtask

    task automatic wait_ip();
        int n;
        n = 0;
        while (!bus.InputPhase && n < 400) begin
            step();
            n++;
        end
        check("input phase reached", 32'(bus.InputPhase), 1);
    endtask

    // Called right after the edge that entered I_FETCH; returns after the key edge.
    task automatic enter(input int d);
        step();
        step();
        bus.PlayerNum  = DIGIT_W'(d);
        bus.PlayerLoad = 1'b1;
        step();
        bus.PlayerLoad = 1'b0;
    endtask

    // Steps through I_WAIT until the cycle carrying the 16th tick.
    task automatic run_to_tick16(output int tc);
        tc = 0;
        for (int n = 0; n < 200; n++) begin
            if (tick) begin
                tc++;
                if (tc == 16) break;
            end
            step();
        end
    endtask

    // Monitor: every output event is matched against the scoreboard.
    initial begin
        logic prev_en, prev_ip, in_gap;
        int   hi_ticks, gap_ticks, v, code;
        logic [ADDR_W-1:0] gap_addr;
        prev_en = 1'b0; prev_ip = 1'b0; in_gap = 1'b0;
        hi_ticks = 0; gap_ticks = 0; gap_addr = '0;
        forever begin
            @(negedge clk);
            if (!bus.Busy) in_gap = 1'b0;
            if (bus.DispEn && !prev_en) begin
                if (disp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected display: digit %0d at t=%0t, none expected", bus.DispDigit, $time);
                end else begin
                    v = disp_q.pop_front();
                    check("display digit", 32'(bus.DispDigit), 32'(v >> 8));
                    check("display address", 32'(bus.SeqAddr), 32'(v & 255));
                end
                hi_ticks = 0;
            end
            if (!bus.DispEn && prev_en && bus.Busy) begin
                check("ticks with display on", 32'(hi_ticks), 4);
                in_gap    = 1'b1;
                gap_ticks = 0;
                gap_addr  = bus.SeqAddr;
            end else if (in_gap && ((bus.SeqAddr != gap_addr) || bus.InputPhase)) begin
                check("ticks of blank gap", 32'(gap_ticks), 2);
                in_gap = 1'b0;
            end
            if (bus.DispEn) hi_ticks += int'(tick);
            if (in_gap) gap_ticks += int'(tick);
            if (bus.InputPhase && !prev_ip) check("input phase start address", 32'(bus.SeqAddr), 0);
            if (bus.Pass || bus.Fail) begin
                code = bus.Pass ? (bus.Fail ? 3 : 0) : (bus.FailCause ? 2 : 1);
                if (res_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected result: code %0d at t=%0t, none expected", code, $time);
                end else begin
                    v = res_q.pop_front();
                    check("round result", 32'(code), 32'(v));
                end
            end
            prev_en = bus.DispEn;
            prev_ip = bus.InputPhase;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, tc;
        n_vec = 0;
        n_err = 0;
        exp_dig = '{9, 11, 13};
        for (int i = 0; i < 32; i++) mem[i] = 4'hF;
        mem[0] = 4'd9; mem[1] = 4'd11; mem[2] = 4'd13;
        rst = 1'b1;
        bus.Start = 1'b0; bus.Level = '0; bus.PlayerLoad = 1'b0; bus.PlayerNum = '0;

        step(); step();
        rst = 1'b0;
        step();
        check("reset outputs", 32'({bus.SeqAddr, bus.DispDigit, bus.DispEn, bus.Busy,
                                   bus.InputPhase, bus.Pass, bus.Fail, bus.FailCause}), 0);

        // Level 2, correct entry; Start and keys during playback are ignored.
        push_round(2, 0);
        start_round(2);
        check("busy after start", 32'(bus.Busy), 1);
        lat = 1;
        while (!bus.DispEn && lat < 10) begin
            step();
            lat++;
        end
        check("first display latency", 32'(lat), 3);
        bus.Level = '0; bus.Start = 1'b1; bus.PlayerLoad = 1'b1; bus.PlayerNum = 4'd9;
        step();
        bus.Start = 1'b0; bus.PlayerLoad = 1'b0;
        wait_ip();
        bus.PlayerNum = 4'd0; bus.PlayerLoad = 1'b1;   // during I_FETCH: dropped
        step();
        bus.PlayerLoad = 1'b0;
        step();
        bus.PlayerNum = 4'd9; bus.PlayerLoad = 1'b1;
        step();
        bus.PlayerLoad = 1'b0;
        enter(11);
        enter(13);
        check("pass pulse", 32'(bus.Pass), 1);
        step();
        check("idle after pass", 32'({bus.Busy, bus.InputPhase, bus.Pass}), 0);

        // Wrong second digit.
        push_round(2, 1);
        start_round(2);
        wait_ip();
        enter(9);
        enter(10);
        check("fail on wrong digit", 32'({bus.Fail, bus.FailCause}), 32'h2);
        step();
        check("idle after wrong digit", 32'(bus.Busy), 0);

        // Timeout on the 16th tick of I_WAIT.
        push_round(2, 2);
        start_round(2);
        wait_ip();
        step(); step();
        run_to_tick16(tc);
        check("timeout tick count reached", 32'(tc), 16);
        check("no fail before 16th tick", 32'({bus.Busy, bus.Fail}), 32'h2);
        step();
        check("fail on timeout", 32'({bus.Fail, bus.FailCause}), 32'h3);
        step();
        check("fail cause held in idle", 32'({bus.Busy, bus.FailCause}), 32'h1);

        // Key coincident with the 16th tick wins over the timeout.
        push_round(2, 0);
        start_round(2);
        check("start clears fail cause", 32'(bus.FailCause), 0);
        wait_ip();
        step(); step();
        run_to_tick16(tc);
        check("coincident tick count reached", 32'(tc), 16);
        bus.PlayerNum = 4'd9; bus.PlayerLoad = 1'b1;
        step();
        bus.PlayerLoad = 1'b0;
        check("key beats timeout", 32'({bus.Fail, bus.InputPhase, bus.SeqAddr}), 32'({1'b0, 1'b1, 5'd1}));
        enter(11);
        enter(13);
        step();
        check("idle after coincident round", 32'(bus.Busy), 0);

        // Level 0: one digit shown, one entry.
        push_round(0, 0);
        start_round(0);
        wait_ip();
        enter(9);
        check("single digit pass", 32'(bus.Pass), 1);
        step();
        check("idle after single digit", 32'(bus.Busy), 0);

        // Reset while the first digit is on display.
        disp_q.push_back((9 << 8) | 0);
        start_round(2);
        lat = 0;
        while (!bus.DispEn && lat < 10) begin
            step();
            lat++;
        end
        step(); step();
        check("showing before reset", 32'(bus.DispEn), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("reset aborts round", 32'({bus.DispEn, bus.Busy, bus.Pass, bus.Fail, bus.SeqAddr}), 0);
        repeat (30) step();
        check("still idle after abort", 32'({bus.Busy, bus.DispEn}), 0);

        check("display queue drained", 32'(disp_q.size()), 0);
        check("result queue drained", 32'(res_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Sequences one round of the memory game: plays back the stored digit sequence from the sequence RAM to the display, then collects and checks the player's entries against the same RAM contents.
Sits between GameController (which issues Start and Level, and consumes Pass/Fail) and the sequence RAM, display driver and player keypad.
Time is counted in Tick pulses from the shared prescaler.

Parameters:
ADDR_W, 5, sequence RAM address width (max 32 digits)
DIGIT_W, 4, digit width
ON_TICKS, 4, ticks each digit is shown
OFF_TICKS, 2, ticks of blank after each digit
TO_TICKS, 16, input timeout in ticks, restarted per digit

Ports:
Clk  in  1  system clock
Rst  in  1  reset
Tick  in  1  one-cycle timebase pulse
Start  in  1  one-cycle pulse that begins a round
Level  in  ADDR_W  round length minus 1 (0 = one digit)
SeqAddr  out  ADDR_W  sequence RAM read address (registered)
RAMOutput  in  DIGIT_W  RAM read data, valid 1 cycle after SeqAddr is sampled
PlayerLoad  in  1  one-cycle pulse: player digit valid
PlayerNum  in  DIGIT_W  player digit
DispDigit  out  DIGIT_W  digit to display
DispEn  out  1  display enable
Busy  out  1  round in progress
InputPhase  out  1  high while awaiting player digits
Pass  out  1  one-cycle pulse: round passed
Fail  out  1  one-cycle pulse: round failed
FailCause  out  1  0 = wrong digit, 1 = timeout; held until next Start

Behaviour:
- Clock and reset: one clock; Rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, idx 0, counters 0. Rst mid-round aborts the round immediately with no Pass or Fail pulse.
- IDLE:
  - Start latches Level into lvl, sets idx=0, SeqAddr=0 and Busy=1, then goes to P_FETCH.
  - Start is ignored in every state other than IDLE.
  - Start clears FailCause.
- Fetch timing (P_FETCH and I_FETCH): each fetch is exactly 2 cycles. SeqAddr is already equal to idx on entry. At the end of the 2nd cycle RAMOutput is latched into exp. Tick is ignored during a fetch.
- Playback phase:
  - P_SHOW: DispDigit=exp and DispEn=1, both registered, asserted from the 1st SHOW cycle. Stay until ON_TICKS Tick pulses are counted, then go to P_GAP.
  - P_GAP: DispEn=0. After OFF_TICKS ticks:
    - if idx<lvl: idx++, SeqAddr=idx+1, go to P_FETCH.
    - else: idx=0, SeqAddr=0, go to I_FETCH.
  - PlayerLoad is ignored throughout playback.
- Input phase:
  - I_FETCH: InputPhase=1 (held through I_WAIT). Timeout counter cleared.
  - I_WAIT: count Tick pulses.
    - PlayerLoad with PlayerNum==exp and idx==lvl: go to PASS.
    - PlayerLoad with PlayerNum==exp and idx<lvl: idx++, SeqAddr++, go to I_FETCH.
    - PlayerLoad with PlayerNum!=exp: FailCause=0, go to FAIL.
    - Count reaches TO_TICKS with no PlayerLoad: FailCause=1, go to FAIL.
    - PlayerLoad in the same cycle as the Tick that would complete the timeout: PlayerLoad wins.
  - PlayerLoad during I_FETCH is ignored and not buffered.
- PASS / FAIL: each lasts one cycle; the Pass or Fail pulse is high for that cycle. Busy=0 and InputPhase=0 on return to IDLE.
- Arithmetic:
  - idx and SeqAddr are ADDR_W bits. With Level=2^ADDR_W-1, idx reaches max without wrapping, because the lvl compare terminates first.
  - Tick counters are sized to clog2(max(ON_TICKS, OFF_TICKS, TO_TICKS)+1).
- Latency: the first DispEn rises 3 cycles after Start is sampled (1 cycle to P_FETCH, plus the 2-cycle fetch).

Decomposition:
- Shared package game_pkg:
  - State encoding enum seq_state_t: IDLE, P_FETCH, P_SHOW, P_GAP, I_FETCH, I_WAIT, PASS, FAIL.
  - Constants FAIL_WRONG=0 and FAIL_TIMEOUT=1.
  - DIGIT_W and ADDR_W defaults shared with GameController.
- One natural sub-module: tick_counter. It is a loadable down-counter of Tick pulses with clear and a done flag, instantiated once and reused for ON, OFF and timeout intervals.

Test Plan (ON_TICKS=4, OFF_TICKS=2, TO_TICKS=16, Tick every 4th cycle; bench RAM model with 1-cycle read, contents 9, 11, 13):
- Rst held 2 cycles, then released -> all outputs 0 and state IDLE. Rst asserted while in P_SHOW -> DispEn=0 and Busy=0 next cycle; no Pass or Fail pulse.
- Start with Level=2 -> SeqAddr steps 0,1,2. DispDigit shows 9, 11, 13, each with DispEn high for exactly 4 ticks and low for 2 ticks. First DispEn 3 cycles after Start. Then InputPhase=1 and SeqAddr=0.
- After playback, PlayerLoad with 9, 11, 13, one per I_WAIT -> Pass pulses 1 cycle, Busy=0, Fail never asserted.
- Same round, PlayerLoad 9 then 10 -> Fail pulse with FailCause=0 immediately after the 10 is sampled.
- Input phase with no PlayerLoad -> Fail pulse with FailCause=1 on the 16th tick. Repeat with PlayerLoad=9 coincident with the 16th tick -> accepted, no Fail, SeqAddr=1.
- Start pulses during playback and PlayerLoad pulses during playback -> no effect on sequence or outputs. Level=0 -> single digit shown, single entry required.
